// File: rtl/ins_queue.sv
// In-order {PC, instruction} queue between fetch and decode.
// Back-pressures fetch through in_ready and discards all entries on a taken-branch flush.
module ins_queue #(
    parameter int              DEPTH = 4,
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = XLEN'(32'h00000013)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_ins,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_ins,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] mem_pc  [DEPTH];
    logic [XLEN-1:0] mem_ins [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Valid/ready: a transfer happens on a rising edge where valid & ready are both 1
    // and flush is 0; in_ready depends on count only, so a full queue refuses a push
    // even while it pops, and an empty queue never forwards in_* straight to out_*.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_pc  = out_valid ? mem_pc[rd_ptr]  : '0;
    assign out_ins = out_valid ? mem_ins[rd_ptr] : NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]  <= '0;
                mem_ins[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]  <= in_pc;
                mem_ins[wr_ptr] <= in_ins;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_queue.sv
// Directed bench for ins_queue: reset, fill, drain with pointer wrap, simultaneous
// push/pop, flush, and full-with-pop behaviour.
module tb_ins_queue;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] TAG  = 32'h5a010000;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_ins;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_ins;
    logic            out_ready;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    ins_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_ins    (in_ins),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_ins   (out_ins),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_ins    = TAG + pc;
        out_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h40, 1'b0);
        tick();
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_ins !== NOP) begin errors++; $display("FAIL reset_out_ins got %h want %h", out_ins, NOP); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        tick();
        checks++; if (count !== 3'd1 || out_pc !== 32'h40 || out_ins !== TAG + 32'h40)
            begin errors++; $display("FAIL first_push got count=%0d pc=%h ins=%h want 1/40/%h", count, out_pc, out_ins, TAG + 32'h40); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL first_pop got count=%0d valid=%b want 0/0", count, out_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0);
            tick();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        drive(1'b1, 32'h10, 1'b0);
        tick();
        checks++; if (count !== 3'd4 || out_pc !== 32'h0) begin errors++; $display("FAIL fill_held got count=%0d pc=%h want 4/0", count, out_pc); end
    endtask

    task automatic test_drain_wrap();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_ins !== TAG + 32'(4 * i))
                begin errors++; $display("FAIL drain_head got v=%b pc=%h ins=%h want pc=%h", out_valid, out_pc, out_ins, 4 * i); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || out_ins !== NOP || out_pc !== 32'h0)
            begin errors++; $display("FAIL drain_empty got v=%b pc=%h ins=%h want 0/0/%h", out_valid, out_pc, out_ins, NOP); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b1);
            tick();
            checks++; if (count !== 3'd1 || out_pc !== 32'h100 + 32'(4 * i))
                begin errors++; $display("FAIL wrap_stream got count=%0d pc=%h want 1/%h", count, out_pc, 32'h100 + 32'(4 * i)); end
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_end got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b0);
            exp_q.push_back(32'h200 + 32'(4 * i));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h208 + 32'(4 * i), 1'b1);
            checks++; if (out_pc !== exp_q[0]) begin errors++; $display("FAIL b2b_order got %h want %h", out_pc, exp_q[0]); end
            void'(exp_q.pop_front());
            exp_q.push_back(32'h208 + 32'(4 * i));
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", count); end
        end
        drive(1'b0, 32'h0, 1'b1);
        while (exp_q.size() > 0) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_q[0]) begin errors++; $display("FAIL b2b_drain got v=%b pc=%h want %h", out_valid, out_pc, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end got %0d want 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", count); end
        drive(1'b1, 32'h30c, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_clear got count=%0d v=%b rdy=%b want 0/0/1", count, out_valid, in_ready); end
        drive(1'b1, 32'h0, 1'b0);
        tick();
        checks++; if (count !== 3'd1 || out_pc !== 32'h0 || out_ins !== TAG)
            begin errors++; $display("FAIL flush_branch got count=%0d pc=%h ins=%h want 1/0/%h", count, out_pc, out_ins, TAG); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_end got %0d want 0", count); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h410, 1'b1);
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_pre got count=%0d rdy=%b want 4/0", count, in_ready); end
        tick();
        checks++; if (count !== 3'd3 || in_ready !== 1'b1 || out_pc !== 32'h404)
            begin errors++; $display("FAIL fullpop_after got count=%0d rdy=%b pc=%h want 3/1/404", count, in_ready, out_pc); end
        drive(1'b1, 32'h410, 1'b0);
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_accept got %0d want 4", count); end
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_pc !== 32'h404 + 32'(4 * i)) begin errors++; $display("FAIL fullpop_drain got %h want %h", out_pc, 32'h404 + 32'(4 * i)); end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fullpop_end got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0);
            tick();
        end
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_ins !== NOP || in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_mid got count=%0d v=%b ins=%h rdy=%b", count, out_valid, out_ins, in_ready); end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
